// File: rtl/vga_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder_if
// Bundles the sampled VGA input stream and the decoded pixel/status outputs
// of vga_sync_decoder.
//   master : the VGA source side (drives pix_en, syncs, blank and colour;
//            observes the decoded pixel stream and status)
//   slave  : the decoder side (the reverse)
// Signals:
//   pix_en                  pixel-sample strobe
//   vga_hs / vga_vs         active-low syncs
//   vga_blank               1 = visible pixel
//   vga_r/g/b               input colour, COL_W bits each
//   pix_valid               one-cycle pulse per decoded visible pixel
//   pix_x / pix_y           visible column / row
//   pix_r/g/b               registered colour
//   pix_sof                 first visible pixel of a frame
//   line_len / frame_lines  last measured samples per line / lines per frame
//   locked                  timing locked
//   err_line / err_frame    one-cycle timing error pulses
// ---------------------------------------------------------------------------
interface vga_sync_decoder_if #(
  parameter int H_CNT_W = 11,
  parameter int V_CNT_W = 10,
  parameter int COL_W   = 4
);
  logic               pix_en;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank;
  logic [COL_W-1:0]   vga_r;
  logic [COL_W-1:0]   vga_g;
  logic [COL_W-1:0]   vga_b;
  logic               pix_valid;
  logic [9:0]         pix_x;
  logic [V_CNT_W-1:0] pix_y;
  logic [COL_W-1:0]   pix_r;
  logic [COL_W-1:0]   pix_g;
  logic [COL_W-1:0]   pix_b;
  logic               pix_sof;
  logic [H_CNT_W-1:0] line_len;
  logic [V_CNT_W-1:0] frame_lines;
  logic               locked;
  logic               err_line;
  logic               err_frame;

  modport master (
    output pix_en, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b,
    input  pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_sof,
    input  line_len, frame_lines, locked, err_line, err_frame
  );

  modport slave (
    input  pix_en, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b,
    output pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_sof,
    output line_len, frame_lines, locked, err_line, err_frame
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Recovers pixel coordinates and line/frame timing from a sampled VGA stream.
// Samples are taken only when pix_en is high; with pix_en low everything
// (counters, sync edge history, lock FSM) is frozen.
// Ports:
//   clk_clk      sole clock, rising edge
//   reset_reset  synchronous active-high reset
//   bus          vga_sync_decoder_if.slave (VGA inputs, decoded outputs)
// Lock FSM: SEARCH waits for a VS fall, MEASURE learns the line length and
// lines per frame over one frame, LOCKED checks every line/frame against the
// learned references and drops back to SEARCH on any mismatch.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_CNT_W = 11,
  parameter int V_CNT_W = 10,
  parameter int COL_W   = 4
) (
  input logic               clk_clk,
  input logic               reset_reset,
  vga_sync_decoder_if.slave bus
);

  localparam logic [H_CNT_W-1:0] H_ZERO = {H_CNT_W{1'b0}};
  localparam logic [H_CNT_W-1:0] H_ONE  = {{(H_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [V_CNT_W-1:0] V_ZERO = {V_CNT_W{1'b0}};
  localparam logic [V_CNT_W-1:0] V_ONE  = {{(V_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [9:0]         X_ZERO = 10'd0;
  localparam logic [9:0]         X_ONE  = 10'd1;
  localparam logic [COL_W-1:0]   C_ZERO = {COL_W{1'b0}};

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [H_CNT_W-1:0] sat_inc_h(input logic [H_CNT_W-1:0] v);
    return (&v) ? v : (v + H_ONE);
  endfunction

  function automatic logic [V_CNT_W-1:0] sat_inc_v(input logic [V_CNT_W-1:0] v);
    return (&v) ? v : (v + V_ONE);
  endfunction

  function automatic logic [9:0] sat_inc_x(input logic [9:0] v);
    return (&v) ? v : (v + X_ONE);
  endfunction

  // sync edge history and timing counters
  logic               prev_hs_r;
  logic               prev_vs_r;
  logic [H_CNT_W-1:0] h_cnt_r;
  logic [V_CNT_W-1:0] v_cnt_r;
  logic [H_CNT_W-1:0] line_len_r;
  logic [V_CNT_W-1:0] frame_lines_r;
  // pixel coordinate tracking
  logic [9:0]         x_cnt_r;
  logic [V_CNT_W-1:0] y_cnt_r;
  logic               line_vis_r;
  // registered pixel outputs
  logic               pix_valid_r;
  logic [9:0]         pix_x_r;
  logic [V_CNT_W-1:0] pix_y_r;
  logic [COL_W-1:0]   pix_r_r;
  logic [COL_W-1:0]   pix_g_r;
  logic [COL_W-1:0]   pix_b_r;
  logic               pix_sof_r;
  // lock FSM
  state_t             state_r;
  state_t             state_s;
  logic [H_CNT_W-1:0] ref_len_r;
  logic [H_CNT_W-1:0] ref_len_s;
  logic [V_CNT_W-1:0] ref_lines_r;
  logic [V_CNT_W-1:0] ref_lines_s;
  logic               err_line_s;
  logic               err_frame_s;
  logic               err_line_r;
  logic               err_frame_r;
  logic               locked_r;

  logic hs_fall_s;
  logic vs_fall_s;
  logic vis_s;

  assign hs_fall_s = bus.pix_en & prev_hs_r & ~bus.vga_hs;
  assign vs_fall_s = bus.pix_en & prev_vs_r & ~bus.vga_vs;
  assign vis_s     = bus.pix_en & bus.vga_blank;

  // sync edge history, samples-per-line and lines-per-frame measurement
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      prev_hs_r     <= 1'b1;
      prev_vs_r     <= 1'b1;
      h_cnt_r       <= H_ZERO;
      v_cnt_r       <= V_ZERO;
      line_len_r    <= H_ZERO;
      frame_lines_r <= V_ZERO;
    end else if (bus.pix_en) begin
      prev_hs_r <= bus.vga_hs;
      prev_vs_r <= bus.vga_vs;
      // the HS-fall sample is counted as sample 1 of the new line
      if (hs_fall_s) begin
        line_len_r <= h_cnt_r;
        h_cnt_r    <= H_ONE;
      end else begin
        h_cnt_r <= sat_inc_h(h_cnt_r);
      end
      // a coincident HS fall already belongs to the new frame
      if (vs_fall_s) begin
        frame_lines_r <= v_cnt_r;
        v_cnt_r       <= hs_fall_s ? V_ONE : V_ZERO;
      end else if (hs_fall_s) begin
        v_cnt_r <= sat_inc_v(v_cnt_r);
      end
    end
  end

  // visible-pixel coordinates and registered pixel outputs (one-cycle latency)
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      x_cnt_r     <= X_ZERO;
      y_cnt_r     <= V_ZERO;
      line_vis_r  <= 1'b0;
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_x_r     <= X_ZERO;
      pix_y_r     <= V_ZERO;
      pix_r_r     <= C_ZERO;
      pix_g_r     <= C_ZERO;
      pix_b_r     <= C_ZERO;
    end else begin
      pix_valid_r <= vis_s;
      pix_sof_r   <= vis_s & (x_cnt_r == X_ZERO) & (y_cnt_r == V_ZERO);
      if (vis_s) begin
        pix_x_r <= x_cnt_r;
        pix_y_r <= y_cnt_r;
        pix_r_r <= bus.vga_r;
        pix_g_r <= bus.vga_g;
        pix_b_r <= bus.vga_b;
      end
      if (bus.pix_en) begin
        if (hs_fall_s) begin
          x_cnt_r <= X_ZERO;
        end else if (vis_s) begin
          x_cnt_r <= sat_inc_x(x_cnt_r);
        end
        // line_vis_r remembers whether the line now ending carried pixels
        if (hs_fall_s) begin
          line_vis_r <= vis_s;
        end else if (vis_s) begin
          line_vis_r <= 1'b1;
        end
        if (vs_fall_s) begin
          y_cnt_r <= V_ZERO;
        end else if (hs_fall_s && line_vis_r) begin
          y_cnt_r <= sat_inc_v(y_cnt_r);
        end
      end
    end
  end

  // lock FSM next-state, reference capture and error detection
  always_comb begin
    state_s     = state_r;
    ref_len_s   = ref_len_r;
    ref_lines_s = ref_lines_r;
    err_line_s  = 1'b0;
    err_frame_s = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (vs_fall_s) begin
          state_s   = ST_MEASURE;
          ref_len_s = H_ZERO;
        end else begin
          state_s = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        // a line that disagrees with the first measured one aborts silently
        if (hs_fall_s && (ref_len_r != H_ZERO) && (h_cnt_r != ref_len_r)) begin
          state_s = ST_SEARCH;
        end else if (vs_fall_s) begin
          if ((ref_len_r != H_ZERO) && (v_cnt_r != V_ZERO)) begin
            state_s     = ST_LOCKED;
            ref_lines_s = v_cnt_r;
          end else begin
            state_s = ST_SEARCH;
          end
        end else begin
          state_s = ST_MEASURE;
        end
        if (hs_fall_s && (ref_len_r == H_ZERO) && (h_cnt_r != H_ZERO)) begin
          ref_len_s = h_cnt_r;
        end else begin
          ref_len_s = ref_len_r;
        end
      end
      ST_LOCKED: begin
        if (hs_fall_s && (h_cnt_r != ref_len_r)) begin
          err_line_s = 1'b1;
        end else begin
          err_line_s = 1'b0;
        end
        if (vs_fall_s && (v_cnt_r != ref_lines_r)) begin
          err_frame_s = 1'b1;
        end else begin
          err_frame_s = 1'b0;
        end
        if (err_line_s || err_frame_s) begin
          state_s = ST_SEARCH;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_SEARCH;
      end
    endcase
  end

  // lock FSM state, references and registered status outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r     <= ST_SEARCH;
      ref_len_r   <= H_ZERO;
      ref_lines_r <= V_ZERO;
      err_line_r  <= 1'b0;
      err_frame_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      ref_len_r   <= ref_len_s;
      ref_lines_r <= ref_lines_s;
      err_line_r  <= err_line_s;
      err_frame_r <= err_frame_s;
      locked_r    <= (state_s == ST_LOCKED);
    end
  end

  assign bus.pix_valid   = pix_valid_r;
  assign bus.pix_x       = pix_x_r;
  assign bus.pix_y       = pix_y_r;
  assign bus.pix_r       = pix_r_r;
  assign bus.pix_g       = pix_g_r;
  assign bus.pix_b       = pix_b_r;
  assign bus.pix_sof     = pix_sof_r;
  assign bus.line_len    = line_len_r;
  assign bus.frame_lines = frame_lines_r;
  assign bus.locked      = locked_r;
  assign bus.err_line    = err_line_r;
  assign bus.err_frame   = err_frame_r;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL provide parameter H_CNT_W, default 11, horizontal sample counter / line_len width.
REQ-002 SHALL provide parameter V_CNT_W, default 10, line counter / frame_lines / pix_y width.
REQ-003 SHALL provide parameter COL_W, default 4, width per colour channel.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have reset_reset  in  1  synchronous active-high reset.
REQ-006 SHALL have pix_en  in  1  pixel-sample strobe; VGA inputs are sampled only when high.
REQ-007 SHALL have vga_hs, vga_vs  in  1 each  active-low syncs.
REQ-008 SHALL have vga_blank  in  1  active-low blank (1 = visible pixel).
REQ-009 SHALL have vga_r, vga_g, vga_b  in  COL_W each  pixel colour.
REQ-010 SHALL have pix_valid  out  1  one-cycle pulse per decoded visible pixel.
REQ-011 SHALL have pix_x  out  10  visible column; pix_y  out  V_CNT_W  visible row.
REQ-012 SHALL have pix_r, pix_g, pix_b  out  COL_W each  registered colour.
REQ-013 SHALL have pix_sof  out  1  pulse with the first visible pixel of a frame.
REQ-014 SHALL have line_len  out  H_CNT_W  last measured samples per line; frame_lines  out  V_CNT_W  last measured lines per frame.
REQ-015 SHALL have locked  out  1; err_line, err_frame  out  1 each  one-cycle error pulses.

Function
REQ-016 Registers prev_hs/prev_vs SHALL update only on pix_en; HS/VS fall = pix_en & prev=1 & current=0.
REQ-017 h_cnt SHALL increment (saturating at all-ones) per pix_en sample; on HS fall, line_len <= h_cnt and h_cnt <= 1.
REQ-018 v_cnt SHALL increment (saturating) per HS fall; on VS fall, frame_lines <= v_cnt and v_cnt <= 0, or 1 if HS fall coincides.
REQ-019 Visible sample (pix_en & vga_blank): next cycle pix_valid=1, pix_x=x_cnt, pix_y=y_cnt, colour registered; latency exactly 1 cycle.
REQ-020 x_cnt SHALL increment per visible sample, saturate at 1023, clear on HS fall.
REQ-021 y_cnt SHALL increment on HS fall if the ending line held >=1 visible sample (saturating); clear on VS fall, VS clear taking priority.
REQ-022 pix_sof SHALL assert with pix_valid when x_cnt=0 and y_cnt=0.
REQ-023 FSM states SEARCH, MEASURE, LOCKED; locked=1 only in LOCKED.
REQ-024 SEARCH -> MEASURE on VS fall; ref_len <= 0 (unset).
REQ-025 MEASURE: on first HS fall after a non-zero line ref_len <= measured length; later mismatching HS fall -> SEARCH, no error pulse.
REQ-026 MEASURE -> LOCKED on next VS fall if ref_len non-zero and v_cnt non-zero; ref_lines <= v_cnt; else -> SEARCH.
REQ-027 LOCKED: HS fall with measured length != ref_len -> err_line pulse, -> SEARCH.
REQ-028 LOCKED: VS fall with v_cnt != ref_lines -> err_frame pulse, -> SEARCH; simultaneous line and frame mismatch pulses both.
REQ-029 pix_en low SHALL freeze all counters, edge registers and FSM; pix_valid=0 that cycle's successor.
REQ-030 Pixel decoding (REQ-019..022) SHALL operate in every FSM state.

Reset
REQ-031 Reset SHALL force all outputs to 0, counters/refs to 0, FSM to SEARCH, prev_hs=prev_vs=1.
REQ-032 Reset asserted mid-frame SHALL take effect next edge; no error pulse emitted; re-lock requires full SEARCH->MEASURE->LOCKED sequence.

Verification
REQ-033 640x480@60 stimulus (800x525, pix_en every 2nd cycle), 3 frames -> locked=1 after second VS fall, line_len=800, frame_lines=525, no error pulses.
REQ-034 Same stream -> exactly 307200 pix_valid per frame, last pixel (639,479), pix_sof once per frame at (0,0), colour equals input one cycle later.
REQ-035 While locked, one line shortened to 799 samples -> err_line pulses once at that HS fall, locked drops, relocks two VS falls later.
REQ-036 While locked, frame with 524 lines -> err_frame pulse at VS fall, locked=0.
REQ-037 HS and VS falling on same sample -> next frame_lines=525, v_cnt restarts at 1.
REQ-038 reset_reset pulsed mid-line with pix_en random 50% -> all outputs 0 next cycle, no spurious edge, clean relock.
